rf_wport_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order writeback path (WB) and a long-latency unit (LL: loads, mul/div, CSR read-back), and keeps a register scoreboard so decode stalls on operands that an LL instruction still owes. It sits between the writeback stage, the LL unit and the decode stage's register file, and drives the register file's `rd`/`wd`/`we` inputs. WB has priority. A wait counter plus a one-entry WB buffer guarantee LL forward progress.

---
 rtl/rf_wport_arbiter.sv | 118 +++++++++++
 tb/tb_rf_wport_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has priority, LL is forced through after
// MAX_WAIT refusals. A scoreboard stalls decode on registers still owed by LL.
module rf_wport_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_dat_i,
    output logic        hold_o,
    input  logic        ll_valid_i,
    input  logic [4:0]  ll_rd_i,
    input  logic [31:0] ll_dat_i,
    output logic        ll_ready_o,
    input  logic        ll_issue_i,
    input  logic [4:0]  ll_issue_rd_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    output logic        stall_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_wd_o
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } wr_req_t;

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic        buf_valid;
    wr_req_t     buf_q;
    logic [3:0]  wait_cnt;
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic        ll_wr_q;

    logic        starve;
    logic        grant_buf;
    logic        grant_wb;
    logic        grant_ll;
    logic        capture_wb;
    logic        wr_en;
    wr_req_t     wr_sel;

    // Buffer drains first, so the buffer can never be refilled while full.
    always_comb begin
        starve     = (wait_cnt >= WAIT_LIM);
        grant_buf  = buf_valid;
        grant_wb   = !buf_valid && wb_we_i && !starve;
        grant_ll   = !buf_valid && ll_valid_i && (starve || !wb_we_i);
        capture_wb = grant_ll && wb_we_i;
        wr_en      = grant_buf || grant_wb || grant_ll;
        wr_sel     = '0;
        if (grant_buf) begin
            wr_sel = buf_q;
        end else if (grant_wb) begin
            wr_sel.rd  = wb_rd_i;
            wr_sel.dat = wb_dat_i;
        end else if (grant_ll) begin
            wr_sel.rd  = ll_rd_i;
            wr_sel.dat = ll_dat_i;
        end
    end

    assign ll_ready_o = grant_ll && rst_i;
    assign hold_o     = buf_valid && rst_i;
    assign stall_o    = pending[id_rs1_i] | pending[id_rs2_i];

    // Clear lands when the LL write is on rf_*; a same-cycle new issue wins.
    always_comb begin
        pending_nxt = pending;
        if (ll_wr_q) begin
            pending_nxt[rf_rd_o] = 1'b0;
        end
        if (ll_issue_i && (ll_issue_rd_i != 5'd0)) begin
            pending_nxt[ll_issue_rd_i] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            buf_valid <= 1'b0;
            buf_q     <= '0;
            wait_cnt  <= '0;
            pending   <= '0;
            ll_wr_q   <= 1'b0;
            rf_we_o   <= 1'b0;
            rf_rd_o   <= '0;
            rf_wd_o   <= '0;
        end else begin
            buf_valid <= capture_wb;
            if (capture_wb) begin
                buf_q.rd  <= wb_rd_i;
                buf_q.dat <= wb_dat_i;
            end

            if (ll_ready_o || !ll_valid_i) begin
                wait_cnt <= '0;
            end else if (wait_cnt != 4'hf) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            pending <= pending_nxt;
            ll_wr_q <= grant_ll;

            rf_we_o <= wr_en && (wr_sel.rd != 5'd0);
            if (wr_en) begin
                rf_rd_o <= wr_sel.rd;
                rf_wd_o <= wr_sel.dat;
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scenario bench for rf_wport_arbiter: expected register-file writes are queued
// as stimulus is driven and popped by a monitor when rf_we_o fires.
module tb_rf_wport_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_dat_i;
    logic        hold_o;
    logic        ll_valid_i;
    logic [4:0]  ll_rd_i;
    logic [31:0] ll_dat_i;
    logic        ll_ready_o;
    logic        ll_issue_i;
    logic [4:0]  ll_issue_rd_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_wd_o;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    rf_wport_arbiter #(.MAX_WAIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_dat_i(wb_dat_i), .hold_o(hold_o),
        .ll_valid_i(ll_valid_i), .ll_rd_i(ll_rd_i), .ll_dat_i(ll_dat_i), .ll_ready_o(ll_ready_o),
        .ll_issue_i(ll_issue_i), .ll_issue_rd_i(ll_issue_rd_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .stall_o(stall_o),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_wd_o(rf_wd_o)
    );

    always #5 clk_i = ~clk_i;

    // Every visible register-file write must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (rf_we_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rf_write: unexpected write rd=%0d wd=%h, none expected", rf_rd_o, rf_wd_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rf_rd_o !== e.rd || rf_wd_o !== e.dat) begin
                    bad++;
                    $display("FAIL rf_write: got rd=%0d wd=%h, want rd=%0d wd=%h", rf_rd_o, rf_wd_o, e.rd, e.dat);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we_i = 0; wb_rd_i = 0; wb_dat_i = 0;
        ll_valid_i = 0; ll_rd_i = 0; ll_dat_i = 0;
        ll_issue_i = 0; ll_issue_rd_i = 0;
        id_rs1_i = 0; id_rs2_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 0;
        idle_inputs();
        ll_valid_i = 1; ll_rd_i = 5'd4; ll_dat_i = 32'h1234;
        wb_we_i = 1; wb_rd_i = 5'd6;
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        total++;
        if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_wd_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_rf: got we=%b rd=%0d wd=%h, want 0/0/0", rf_we_o, rf_rd_o, rf_wd_o);
        end
        total++;
        if (ll_ready_o !== 1'b0 || hold_o !== 1'b0 || stall_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: got ready=%b hold=%b stall=%b, want 0/0/0", ll_ready_o, hold_o, stall_o);
        end
        next_cycle();
        rst_i = 1;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_single_wb();
        wb_we_i = 1; wb_rd_i = 5'd5; wb_dat_i = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk_i);
        total++;
        if (hold_o !== 1'b0) begin
            bad++;
            $display("FAIL single_hold: got %b want 0", hold_o);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        total++;
        if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd5) begin
            bad++;
            $display("FAIL single_wb: got we=%b rd=%0d, want 1/5", rf_we_o, rf_rd_o);
        end
        next_cycle();
    endtask

    // WB every cycle with LL waiting: LL forced through on cycle 5, buffer drains on 6.
    task automatic test_starve();
        int k = 0;
        for (int c = 1; c <= 7; c++) begin
            wb_we_i = 1; wb_rd_i = 5'(10 + k); wb_dat_i = 32'hB000_0000 + k;
            ll_valid_i = (c <= 5); ll_rd_i = 5'd7; ll_dat_i = 32'h11;
            if (c == 5) exp_q.push_back({5'd7, 32'h11});
            if (c != 6) exp_q.push_back({5'(10 + k), 32'hB000_0000 + k});
            @(negedge clk_i);
            total++;
            if (ll_ready_o !== (c == 5)) begin
                bad++;
                $display("FAIL starve_ready c%0d: got %b want %b", c, ll_ready_o, (c == 5));
            end
            total++;
            if (hold_o !== (c == 6)) begin
                bad++;
                $display("FAIL starve_hold c%0d: got %b want %b", c, hold_o, (c == 6));
            end
            if (c == 6) begin
                total++;
                if (rf_rd_o !== 5'd7 || rf_wd_o !== 32'h11) begin
                    bad++;
                    $display("FAIL starve_ll_write: got rd=%0d wd=%h want 7/11", rf_rd_o, rf_wd_o);
                end
            end
            if (c != 6) k++;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_scoreboard();
        logic exp_stall [0:5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c <= 5; c++) begin
            idle_inputs();
            id_rs1_i = 5'd9;
            if (c == 0) begin ll_issue_i = 1; ll_issue_rd_i = 5'd9; end
            if (c == 3) begin
                ll_valid_i = 1; ll_rd_i = 5'd9; ll_dat_i = 32'h99;
                exp_q.push_back({5'd9, 32'h99});
            end
            @(negedge clk_i);
            total++;
            if (stall_o !== exp_stall[c]) begin
                bad++;
                $display("FAIL sb_stall c%0d: got %b want %b", c, stall_o, exp_stall[c]);
            end
            if (c == 3) begin
                total++;
                if (ll_ready_o !== 1'b1) begin
                    bad++;
                    $display("FAIL sb_ready: got %b want 1", ll_ready_o);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_rd0();
        ll_issue_i = 1; ll_issue_rd_i = 5'd0;
        next_cycle();
        idle_inputs();
        ll_valid_i = 1; ll_rd_i = 5'd0; ll_dat_i = 32'h55;
        @(negedge clk_i);
        total++;
        if (stall_o !== 1'b0 || ll_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL rd0_issue: got stall=%b ready=%b want 0/1", stall_o, ll_ready_o);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        total++;
        if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_wd_o !== 32'h55) begin
            bad++;
            $display("FAIL rd0_write: got we=%b rd=%0d wd=%h want 0/0/55", rf_we_o, rf_rd_o, rf_wd_o);
        end
        next_cycle();
    endtask

    // A re-issue to x3 on the cycle its previous LL write clears must keep it pending.
    task automatic test_set_wins();
        logic exp_stall [0:5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c <= 5; c++) begin
            idle_inputs();
            id_rs2_i = 5'd3;
            if (c == 0 || c == 2) begin ll_issue_i = 1; ll_issue_rd_i = 5'd3; end
            if (c == 1) begin
                ll_valid_i = 1; ll_rd_i = 5'd3; ll_dat_i = 32'h33;
                exp_q.push_back({5'd3, 32'h33});
            end
            if (c == 3) begin
                ll_valid_i = 1; ll_rd_i = 5'd3; ll_dat_i = 32'h34;
                exp_q.push_back({5'd3, 32'h34});
            end
            @(negedge clk_i);
            total++;
            if (stall_o !== exp_stall[c]) begin
                bad++;
                $display("FAIL setwins_stall c%0d: got %b want %b", c, stall_o, exp_stall[c]);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        ll_issue_i = 1; ll_issue_rd_i = 5'd20;
        next_cycle();
        for (int c = 1; c <= 5; c++) begin
            idle_inputs();
            id_rs1_i = 5'd20;
            wb_we_i = 1; wb_rd_i = 5'(22 + c); wb_dat_i = 32'hC000_0000 + c;
            ll_valid_i = 1; ll_rd_i = 5'd21; ll_dat_i = 32'h2121;
            if (c < 5) exp_q.push_back({5'(22 + c), 32'hC000_0000 + c});
            else       exp_q.push_back({5'd21, 32'h2121});
            @(negedge clk_i);
            total++;
            if (ll_ready_o !== (c == 5)) begin
                bad++;
                $display("FAIL rmid_ready c%0d: got %b want %b", c, ll_ready_o, (c == 5));
            end
            next_cycle();
        end
        // Buffer is full now; reset before it drains.
        rst_i = 0;
        ll_valid_i = 0;
        wb_rd_i = 5'd30; wb_dat_i = 32'hDEAD0000;
        @(negedge clk_i);
        total++;
        if (hold_o !== 1'b0 || ll_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL rmid_in_reset: got hold=%b ready=%b want 0/0", hold_o, ll_ready_o);
        end
        next_cycle();
        next_cycle();
        rst_i = 1;
        idle_inputs();
        id_rs1_i = 5'd20;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            total++;
            if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_wd_o !== 32'd0 || hold_o !== 1'b0 || stall_o !== 1'b0) begin
                bad++;
                $display("FAIL rmid_after c%0d: got we=%b rd=%0d wd=%h hold=%b stall=%b want all 0",
                         c, rf_we_o, rf_rd_o, rf_wd_o, hold_o, stall_o);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single_wb();
        test_starve();
        test_scoreboard();
        test_rd0();
        test_set_wins();
        test_reset_mid();
        next_cycle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d writes never appeared, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
